// File: rtl/adda_pkg.sv
// Shared definitions for the DAC output path: pacer states, midscale helper
// and the default sample width.
package adda_pkg;

   localparam int DEFAULT_DATA_WIDTH = 14;

   typedef enum logic {
      PRIME = 1'b0,
      RUN   = 1'b1
   } pacer_state_t;

   // Offset-binary zero: MSB set, all other bits clear.
   function automatic logic [31:0] midscale(input int width);
      return 32'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; the head word is read
// combinationally from the memory array.
module sync_fifo #(
   parameter int DATA_WIDTH = 14,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [DATA_WIDTH-1:0]        wdata,
   output logic [DATA_WIDTH-1:0]        rdata,
   output logic [$clog2(FIFO_DEPTH):0]  count,
   output logic                         full,
   output logic                         empty
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]     r_wr_ptr;
   logic [ADDR_W-1:0]     r_rd_ptr;
   logic [ADDR_W:0]       r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   assign full      = (r_count == (ADDR_W + 1)'(FIFO_DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign rdata     = r_mem[r_rd_ptr];
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   // NOTE: the storage array has no reset; clearing pointers and count is
   // enough to discard its contents, and it keeps the array as plain RAM.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= wdata;
   end

   // NOTE: state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
            2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dac_out_pacer.sv
// Paces buffered offset-binary samples to a DAC, one every RATE_DIV clocks.
// Optional sticky underrun event counter: DAC_OUT_PACER_UNDERRUN_CNT_EN.
module dac_out_pacer
   import adda_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int FIFO_DEPTH = 8,
   parameter int RATE_DIV   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] dsoutdata,
   input  logic                  in_en,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] dac_data,
   output logic                  dac_wrt,
   output logic                  underrun,
   input  logic                  underrun_clr
`ifdef DAC_OUT_PACER_UNDERRUN_CNT_EN
   ,
   output logic [15:0]           underrun_cnt
`endif
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int DIV_W  = $clog2(RATE_DIV);
   localparam logic [DATA_WIDTH-1:0] MID_CODE = DATA_WIDTH'(midscale(DATA_WIDTH));
   localparam logic [ADDR_W:0]       HALF_CNT = (ADDR_W + 1)'(FIFO_DEPTH / 2);
   localparam logic [DIV_W-1:0]      DIV_MAX  = DIV_W'(RATE_DIV - 1);
   localparam logic [DIV_W-1:0]      DIV_HALF = DIV_W'(RATE_DIV / 2);

   pacer_state_t          r_state;
   pacer_state_t          w_state_next;
   logic [DIV_W-1:0]      r_div_cnt;
   logic [DIV_W-1:0]      w_div_next;
   logic                  w_tick;
   logic                  w_pop;
   logic                  w_underrun_set;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic [ADDR_W:0]       w_count;
   logic                  w_full;
   logic                  w_empty;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_en),
      .pop   (w_pop),
      .wdata (dsoutdata),
      .rdata (w_rdata),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

   assign busy       = w_full;
   assign w_tick     = (r_div_cnt == DIV_MAX);
   assign w_div_next = w_tick ? '0 : r_div_cnt + DIV_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= PRIME;
         r_div_cnt <= '0;
      end else begin
         r_state   <= w_state_next;
         r_div_cnt <= w_div_next;
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_state_next   = r_state;
      w_pop          = 1'b0;
      w_underrun_set = 1'b0;
      if (w_tick) begin
         case (r_state)
            PRIME: if (w_count >= HALF_CNT) w_state_next = RUN;
            RUN: begin
               if (w_empty) begin
                  w_underrun_set = 1'b1;
                  w_state_next   = PRIME;
               end else begin
                  w_pop = 1'b1;
               end
            end
            default: w_state_next = PRIME;
         endcase
      end
   end

   // The DAC latches on the rising dac_wrt edge, half a period after data moves.
   always_ff @(posedge clk) begin
      if (rst) begin
         dac_data <= MID_CODE;
         dac_wrt  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         dac_wrt <= (w_div_next >= DIV_HALF);
         if (w_pop) dac_data <= w_rdata;
         if (w_underrun_set)    underrun <= 1'b1;
         else if (underrun_clr) underrun <= 1'b0;
      end
   end

`ifdef DAC_OUT_PACER_UNDERRUN_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         underrun_cnt <= '0;
      end else if (w_underrun_set) begin
         if (underrun_clr)                underrun_cnt <= 16'd1;
         else if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      end else if (underrun_clr) begin
         underrun_cnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_dac_out_pacer.sv
// Scoreboard bench for dac_out_pacer: accepted samples are queued at drive
// time and matched against each dac_data update.
module tb_dac_out_pacer;
   import adda_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] dsoutdata = '0;
   logic        in_en = 1'b0;
   logic        busy;
   logic [13:0] dac_data;
   logic        dac_wrt;
   logic        underrun;
   logic        underrun_clr = 1'b0;
`ifdef DAC_OUT_PACER_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
`endif

   int          n_checks = 0;
   int          n_pass   = 0;
   int          ph       = 0;
   logic        rst_q    = 1'b1;
   logic [13:0] prev_data;
   logic [13:0] exp_q [$];

   dac_out_pacer dut (
      .clk          (clk),
      .rst          (rst),
      .dsoutdata    (dsoutdata),
      .in_en        (in_en),
      .busy         (busy),
      .dac_data     (dac_data),
      .dac_wrt      (dac_wrt),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
`ifdef DAC_OUT_PACER_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // Reference phase of the sample period (0..3), independent of the DUT.
   always @(posedge clk) begin
      ph    <= rst ? 0 : ((ph == 3) ? 0 : ph + 1);
      rst_q <= rst;
   end

   always @(negedge clk) begin
      if (rst_q) begin
         prev_data = dac_data;
      end else begin
         check("dac_wrt_phase", 32'(dac_wrt), 32'(ph >= 2));
         if (dac_data !== prev_data) begin
            if (exp_q.size() == 0) begin
               check("unexpected_update", 32'(dac_data), 32'(prev_data));
            end else begin
               check("dac_data", 32'(dac_data), 32'(exp_q.pop_front()));
               check("update_phase", 32'(ph), 32'd0);
            end
            prev_data = dac_data;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_en = 1'b0;
      @(negedge clk);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send(input logic [13:0] d);
      in_en = 1'b1;
      dsoutdata = d;
      exp_q.push_back(d);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset values and dac_wrt waveform
      do_reset();
      check("rst_dac_data", 32'(dac_data), 32'h2000);
      check("rst_dac_wrt", 32'(dac_wrt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
`ifdef DAC_OUT_PACER_UNDERRUN_CNT_EN
      check("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check("wrt_period", 32'(dac_wrt), 32'((i % 4) >= 2));
      end

      // Priming, playback of four samples, then underrun on the fifth RUN tick
      do_reset();
      for (int i = 1; i <= 4; i++) send(14'(i));
      in_en = 1'b0;
      cycles(7);
      check("prime_hold", 32'(dac_data), 32'h2000);
      cycles(16);
      check("no_underrun_yet", 32'(underrun), 32'd0);
      check("prime_drained", 32'(exp_q.size()), 32'd0);
      cycles(1);
      check("underrun_set", 32'(underrun), 32'd1);
      check("underrun_hold", 32'(dac_data), 32'h0004);
      check("underrun_state", 32'(dut.r_state), 32'(PRIME));
`ifdef DAC_OUT_PACER_UNDERRUN_CNT_EN
      check("underrun_cnt_1", 32'(underrun_cnt), 32'd1);
`endif
      underrun_clr = 1'b1;
      cycles(1);
      underrun_clr = 1'b0;
      check("underrun_clr", 32'(underrun), 32'd0);
`ifdef DAC_OUT_PACER_UNDERRUN_CNT_EN
      check("underrun_cnt_clr", 32'(underrun_cnt), 32'd0);
`endif

      // Backpressure: eight accepted, ninth held off while full
      do_reset();
      for (int i = 0; i < 8; i++) begin
         check("busy_low", 32'(busy), 32'd0);
         send(14'h0100 + 14'(i));
      end
      dsoutdata = 14'h3FFF;
      for (int i = 0; i < 4; i++) begin
         check("busy_full", 32'(busy), 32'd1);
         @(negedge clk);
      end
      in_en = 1'b0;
      check("busy_after_pop", 32'(busy), 32'd0);
      cycles(29);
      check("full_drained", 32'(exp_q.size()), 32'd0);
      check("full_last", 32'(dac_data), 32'h0107);

      // Steady state: one push per tick, pointers wrap several times
      do_reset();
      for (int i = 0; i < 4; i++) send(14'h0200 + 14'(i));
      in_en = 1'b0;
      begin
         int sent = 0;
         while (sent < 20) begin
            if (ph == 3) begin
               in_en = 1'b1;
               dsoutdata = 14'h0210 + 14'(sent);
               exp_q.push_back(dsoutdata);
               sent++;
            end else begin
               in_en = 1'b0;
            end
            @(negedge clk);
         end
      end
      in_en = 1'b0;
      check("steady_count", 32'(dut.w_count), 32'd5);
      check("steady_no_underrun", 32'(underrun), 32'd0);

      // Reset with five entries buffered
      rst = 1'b1;
      @(negedge clk);
      exp_q.delete();
      check("midrst_dac_data", 32'(dac_data), 32'h2000);
      check("midrst_empty", 32'(dut.w_empty), 32'd1);
      check("midrst_state", 32'(dut.r_state), 32'(PRIME));
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_dac_wrt", 32'(dac_wrt), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) send(14'h0300 + 14'(i));
      in_en = 1'b0;
      cycles(21);
      check("post_rst_drained", 32'(exp_q.size()), 32'd0);
      check("post_rst_last", 32'(dac_data), 32'h0303);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
